// File: rtl/fpu_fmul_pipe.sv
// -----------------------------------------------------------------------------
// fpu_fmul_pipe
// Parametrised, fully pipelined IEEE-754-style floating-point multiplier.
// Four register stages (S1 unpack/classify, S2 multiply, S3 normalise,
// S4 round/pack) with valid/ready backpressure. The whole pipe freezes while
// the output holds a result the downstream has not taken. Subnormal inputs are
// treated as zero and tiny results are flushed to zero. Rounding is
// round-to-nearest, ties-to-even.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   in_valid   in   operands/tag valid this cycle
//   in_ready   out  pipe accepts when in_valid && in_ready
//   a, b       in   operands, W = 1+EXP_W+MAN_W bits
//   in_tag     in   opaque tag carried alongside the operation
//   out_valid  out  result valid
//   out_ready  in   downstream accepts when out_valid && out_ready
//   q          out  product
//   out_tag    out  tag of the result
//   flags      out  {invalid, overflow, underflow, inexact}
// -----------------------------------------------------------------------------
module fpu_fmul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     q,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       flags
);

    // Exponent arithmetic is done in EXP_W+2 bits so that both the
    // underflow (negative) and overflow (> 2^EXP_W-1) ranges are representable.
    localparam int EW2 = EXP_W + 2;
    localparam int PW  = 2 * MAN_W + 2;

    localparam logic [EW2-1:0]        BIAS     = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic signed [EW2-1:0] EXP_ONE  = {{(EW2-1){1'b0}}, 1'b1};
    localparam logic signed [EW2-1:0] EXP_ZERO = {EW2{1'b0}};
    localparam logic signed [EW2-1:0] EXP_MAX  = {2'b00, {EXP_W{1'b1}}};
    localparam logic [W-1:0]          QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Result class decided in S1; anything but CLS_NUM overrides the arithmetic.
    typedef enum logic [1:0] {
        CLS_NUM  = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_QNAN = 2'd3
    } cls_e;

    // ------------------------------------------------------------------
    // Flow control: every stage advances together unless the output is
    // holding a result that is not being taken.
    // ------------------------------------------------------------------
    logic w_stall;
    logic w_advance;

    assign w_stall   = out_valid & ~out_ready;
    assign w_advance = ~w_stall;
    assign in_ready  = ~w_stall;

    // ------------------------------------------------------------------
    // S1 combinational: unpack and classify
    // ------------------------------------------------------------------
    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_a_emax, w_b_emax, w_a_zero, w_b_zero;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_snan, w_b_snan;
    logic [EW2-1:0]   w_exp_sum;
    cls_e             w_cls;
    logic             w_inv;

    assign w_sa = a[W-1];
    assign w_sb = b[W-1];
    assign w_ea = a[W-2:MAN_W];
    assign w_eb = b[W-2:MAN_W];
    assign w_fa = a[MAN_W-1:0];
    assign w_fb = b[MAN_W-1:0];

    assign w_a_emax = &w_ea;
    assign w_b_emax = &w_eb;
    // A zero exponent covers both true zero and subnormals (inputs flushed).
    assign w_a_zero = ~|w_ea;
    assign w_b_zero = ~|w_eb;
    assign w_a_nan  = w_a_emax & (|w_fa);
    assign w_b_nan  = w_b_emax & (|w_fb);
    assign w_a_inf  = w_a_emax & ~(|w_fa);
    assign w_b_inf  = w_b_emax & ~(|w_fb);
    assign w_a_snan = w_a_nan & ~w_fa[MAN_W-1];
    assign w_b_snan = w_b_nan & ~w_fb[MAN_W-1];

    // Biased exponent of the product before normalisation: ea + eb - bias.
    assign w_exp_sum = {2'b00, w_ea} + {2'b00, w_eb} - BIAS;

    // Special-value priority: NaN, inf*zero, inf, zero, ordinary number.
    always_comb begin
        w_cls = CLS_NUM;
        w_inv = 1'b0;
        if (w_a_nan | w_b_nan) begin
            w_cls = CLS_QNAN;
            w_inv = w_a_snan | w_b_snan;
        end else if ((w_a_inf & w_b_zero) | (w_b_inf & w_a_zero)) begin
            w_cls = CLS_QNAN;
            w_inv = 1'b1;
        end else if (w_a_inf | w_b_inf) begin
            w_cls = CLS_INF;
            w_inv = 1'b0;
        end else if (w_a_zero | w_b_zero) begin
            w_cls = CLS_ZERO;
            w_inv = 1'b0;
        end else begin
            w_cls = CLS_NUM;
            w_inv = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // S1 registers
    // ------------------------------------------------------------------
    logic                  r_v1;
    logic                  r_s1_sign;
    logic signed [EW2-1:0] r_s1_exp;
    logic [MAN_W:0]        r_s1_ma, r_s1_mb;
    cls_e                  r_s1_cls;
    logic                  r_s1_inv;
    logic [TAG_W-1:0]      r_s1_tag;

    // S1 stage register: capture unpacked operands on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_exp  <= EXP_ZERO;
            r_s1_ma   <= {(MAN_W+1){1'b0}};
            r_s1_mb   <= {(MAN_W+1){1'b0}};
            r_s1_cls  <= CLS_ZERO;
            r_s1_inv  <= 1'b0;
            r_s1_tag  <= {TAG_W{1'b0}};
        end else if (w_advance) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_s1_sign <= w_sa ^ w_sb;
                r_s1_exp  <= w_exp_sum;
                r_s1_ma   <= {1'b1, w_fa};
                r_s1_mb   <= {1'b1, w_fb};
                r_s1_cls  <= w_cls;
                r_s1_inv  <= w_inv;
                r_s1_tag  <= in_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: mantissa product
    // ------------------------------------------------------------------
    logic [PW-1:0] w_prod;

    assign w_prod = {{(MAN_W+1){1'b0}}, r_s1_ma} * {{(MAN_W+1){1'b0}}, r_s1_mb};

    logic                  r_v2;
    logic                  r_s2_sign;
    logic signed [EW2-1:0] r_s2_exp;
    logic [PW-1:0]         r_s2_prod;
    cls_e                  r_s2_cls;
    logic                  r_s2_inv;
    logic [TAG_W-1:0]      r_s2_tag;

    // S2 stage register: hold the raw product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2      <= 1'b0;
            r_s2_sign <= 1'b0;
            r_s2_exp  <= EXP_ZERO;
            r_s2_prod <= {PW{1'b0}};
            r_s2_cls  <= CLS_ZERO;
            r_s2_inv  <= 1'b0;
            r_s2_tag  <= {TAG_W{1'b0}};
        end else if (w_advance) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2_sign <= r_s1_sign;
                r_s2_exp  <= r_s1_exp;
                r_s2_prod <= w_prod;
                r_s2_cls  <= r_s1_cls;
                r_s2_inv  <= r_s1_inv;
                r_s2_tag  <= r_s1_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: normalise. Product lies in [1,4); if it reached [2,4) the binary
    // point moves one place left and the exponent goes up by one. Otherwise
    // the product is shifted left so the hidden bit always sits at the MSB.
    // ------------------------------------------------------------------
    logic [PW-1:0]         w_norm;
    logic signed [EW2-1:0] w_exp3;

    assign w_norm = r_s2_prod[PW-1] ? r_s2_prod : {r_s2_prod[PW-2:0], 1'b0};
    assign w_exp3 = r_s2_prod[PW-1] ? (r_s2_exp + EXP_ONE) : r_s2_exp;

    logic                  r_v3;
    logic                  r_s3_sign;
    logic signed [EW2-1:0] r_s3_exp;
    logic [MAN_W-1:0]      r_s3_frac;
    logic                  r_s3_g, r_s3_r, r_s3_st;
    cls_e                  r_s3_cls;
    logic                  r_s3_inv;
    logic [TAG_W-1:0]      r_s3_tag;

    // S3 stage register: normalised fraction plus guard/round/sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v3      <= 1'b0;
            r_s3_sign <= 1'b0;
            r_s3_exp  <= EXP_ZERO;
            r_s3_frac <= {MAN_W{1'b0}};
            r_s3_g    <= 1'b0;
            r_s3_r    <= 1'b0;
            r_s3_st   <= 1'b0;
            r_s3_cls  <= CLS_ZERO;
            r_s3_inv  <= 1'b0;
            r_s3_tag  <= {TAG_W{1'b0}};
        end else if (w_advance) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_s3_sign <= r_s2_sign;
                r_s3_exp  <= w_exp3;
                r_s3_frac <= w_norm[PW-2:MAN_W+1];
                r_s3_g    <= w_norm[MAN_W];
                r_s3_r    <= w_norm[MAN_W-1];
                r_s3_st   <= |w_norm[MAN_W-2:0];
                r_s3_cls  <= r_s2_cls;
                r_s3_inv  <= r_s2_inv;
                r_s3_tag  <= r_s2_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // S4 combinational: round to nearest even, range check, pack
    // ------------------------------------------------------------------
    logic                  w_inexact;
    logic                  w_rnd_up;
    logic [MAN_W:0]        w_frac_rnd;
    logic signed [EW2-1:0] w_exp_fin;
    logic                  w_ovf, w_unf;
    logic [W-1:0]          w_q;
    logic [3:0]            w_flags;

    assign w_inexact  = r_s3_g | r_s3_r | r_s3_st;
    // Round up above half, or exactly half with an odd LSB.
    assign w_rnd_up   = r_s3_g & (r_s3_r | r_s3_st | r_s3_frac[0]);
    assign w_frac_rnd = {1'b0, r_s3_frac} + {{MAN_W{1'b0}}, w_rnd_up};
    // On carry-out the fraction bits are already all zero (1.11..1 + ulp = 10.0).
    assign w_exp_fin  = r_s3_exp + (w_frac_rnd[MAN_W] ? EXP_ONE : EXP_ZERO);
    assign w_ovf      = (w_exp_fin >= EXP_MAX);
    assign w_unf      = (w_exp_fin <= EXP_ZERO);

    // Select the packed result and flags according to the operation class.
    always_comb begin
        w_q     = {W{1'b0}};
        w_flags = 4'b0000;
        case (r_s3_cls)
            CLS_QNAN: begin
                w_q     = QNAN;
                w_flags = {r_s3_inv, 3'b000};
            end
            CLS_INF: begin
                w_q     = {r_s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                w_flags = 4'b0000;
            end
            CLS_ZERO: begin
                w_q     = {r_s3_sign, {(W-1){1'b0}}};
                w_flags = 4'b0000;
            end
            CLS_NUM: begin
                if (w_ovf) begin
                    w_q     = {r_s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    w_flags = 4'b0101;
                end else if (w_unf) begin
                    w_q     = {r_s3_sign, {(W-1){1'b0}}};
                    w_flags = 4'b0011;
                end else begin
                    w_q     = {r_s3_sign, w_exp_fin[EXP_W-1:0], w_frac_rnd[MAN_W-1:0]};
                    w_flags = {3'b000, w_inexact};
                end
            end
            default: begin
                w_q     = QNAN;
                w_flags = 4'b0000;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // S4 registers drive the outputs directly
    // ------------------------------------------------------------------
    logic             r_v4;
    logic [W-1:0]     r_q;
    logic [TAG_W-1:0] r_tag;
    logic [3:0]       r_flags;

    // S4 stage register: final result, held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v4    <= 1'b0;
            r_q     <= {W{1'b0}};
            r_tag   <= {TAG_W{1'b0}};
            r_flags <= 4'b0000;
        end else if (w_advance) begin
            r_v4 <= r_v3;
            if (r_v3) begin
                r_q     <= w_q;
                r_tag   <= r_s3_tag;
                r_flags <= w_flags;
            end
        end
    end

    assign out_valid = r_v4;
    assign q         = r_q;
    assign out_tag   = r_tag;
    assign flags     = r_flags;

endmodule

// File: tb/tb_fpu_fmul_pipe.sv
module tb_fpu_fmul_pipe;

    // ---------------- clock / counters ----------------
    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   passes;
    int   n_stall;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- single-precision DUT ----------------
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, q;
    logic [3:0]  in_tag, out_tag, flags;

    fpu_fmul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .out_tag(out_tag), .flags(flags)
    );

    // ---------------- half-precision DUT ----------------
    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_q;
    logic [3:0]  h_in_tag, h_out_tag, h_flags;

    fpu_fmul_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
        .clk(clk), .rst(rst),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .in_tag(h_in_tag),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .q(h_q), .out_tag(h_out_tag), .flags(h_flags)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] q;
        logic [3:0]  tag;
        logic [3:0]  flags;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    exp_t hsb[$];

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    endtask

    // Output monitor for the single-precision DUT, sampled mid-cycle.
    initial begin
        logic        prev_stall;
        logic [31:0] held_q;
        logic [3:0]  held_tag, held_flags;
        exp_t        e;
        prev_stall = 1'b0;
        held_q = 32'h0;
        held_tag = 4'h0;
        held_flags = 4'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (out_valid && !out_ready) begin
                    n_stall++;
                    check("in_ready_stall", {63'h0, in_ready}, 64'h0);
                    if (prev_stall) begin
                        check("stall_q_stable", {32'h0, q}, {32'h0, held_q});
                        check("stall_tag_stable", {60'h0, out_tag}, {60'h0, held_tag});
                        check("stall_flags_stable", {60'h0, flags}, {60'h0, held_flags});
                    end
                    held_q = q;
                    held_tag = out_tag;
                    held_flags = flags;
                    prev_stall = 1'b1;
                end else begin
                    prev_stall = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        $error("FAIL unexpected_out: got tag %0h q %0h expected no result", out_tag, q);
                    end else begin
                        e = sb.pop_front();
                        check("q", {32'h0, q}, {32'h0, e.q});
                        check("out_tag", {60'h0, out_tag}, {60'h0, e.tag});
                        check("flags", {60'h0, flags}, {60'h0, e.flags});
                        if (e.lat) check("latency", 64'(cyc - e.acc), 64'd4);
                    end
                end
            end
        end
    end

    // Output monitor for the half-precision DUT.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && h_out_valid && h_out_ready) begin
                if (hsb.size() == 0) begin
                    checks++;
                    $error("FAIL h_unexpected_out: got q %0h expected no result", h_q);
                end else begin
                    e = hsb.pop_front();
                    check("h_q", {48'h0, h_q}, {32'h0, e.q});
                    check("h_flags", {60'h0, h_flags}, {60'h0, e.flags});
                    check("h_out_tag", {60'h0, h_out_tag}, {60'h0, e.tag});
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Drive one op on the single-precision DUT; called just after a rising edge.
    task automatic send(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] itag,
                        input logic [31:0] eq, input logic [3:0] ef, input bit track, input bit lat);
        exp_t e;
        bit   done;
        done = 1'b0;
        a = ia;
        b = ib;
        in_tag = itag;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (track) begin
                    e.q = eq;
                    e.tag = itag;
                    e.flags = ef;
                    e.acc = cyc;
                    e.lat = lat;
                    sb.push_back(e);
                end
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            $error("FAIL send_timeout: got in_ready 0 expected 1 within 100 cycles");
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (sb.size() != 0 || hsb.size() != 0); i++) @(negedge clk);
        check("drain_empty", 64'(sb.size() + hsb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        exp_t e;
        checks = 0;
        passes = 0;
        n_stall = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = 32'h0;
        b = 32'h0;
        in_tag = 4'h0;
        h_in_valid = 1'b0;
        h_out_ready = 1'b1;
        h_a = 16'h0;
        h_b = 16'h0;
        h_in_tag = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_q", {32'h0, q}, 64'h0);
        check("rst_out_tag", {60'h0, out_tag}, 64'h0);
        check("rst_flags", {60'h0, flags}, 64'h0);
        check("rst_in_ready", {63'h0, in_ready}, 64'h1);
        @(posedge clk);
        #1;

        // Basic op with exact latency check.
        send(32'h3FC00000, 32'h40000000, 4'd3, 32'h40400000, 4'b0000, 1'b1, 1'b1);
        idle();
        drain();

        // Back-to-back directed ops covering arithmetic and special values.
        send(32'hC0000000, 32'h40400000, 4'd1, 32'hC0C00000, 4'b0000, 1'b1, 1'b1);
        send(32'h3F800001, 32'h3F800001, 4'd2, 32'h3F800002, 4'b0001, 1'b1, 1'b1);
        send(32'h3F800800, 32'h3F800800, 4'd4, 32'h3F801000, 4'b0001, 1'b1, 1'b1);
        send(32'h7F000000, 32'h7F000000, 4'd5, 32'h7F800000, 4'b0101, 1'b1, 1'b1);
        send(32'h00800000, 32'h3F000000, 4'd6, 32'h00000000, 4'b0011, 1'b1, 1'b1);
        send(32'h7F800000, 32'h00000000, 4'd7, 32'h7FC00000, 4'b1000, 1'b1, 1'b1);
        send(32'h7F800001, 32'h3F800000, 4'd8, 32'h7FC00000, 4'b1000, 1'b1, 1'b1);
        send(32'h7FC00001, 32'h3F800000, 4'd9, 32'h7FC00000, 4'b0000, 1'b1, 1'b1);
        send(32'hFF800000, 32'h40000000, 4'd10, 32'hFF800000, 4'b0000, 1'b1, 1'b1);
        send(32'h80000000, 32'h3F800000, 4'd11, 32'h80000000, 4'b0000, 1'b1, 1'b1);
        send(32'h00000001, 32'h3F800000, 4'd12, 32'h00000000, 4'b0000, 1'b1, 1'b1);
        send(32'h3FFFFFFF, 32'h3FFFFFFF, 4'd13, 32'h407FFFFE, 4'b0001, 1'b1, 1'b1);
        idle();
        drain();

        // Backpressure: 8 ops, out_ready low for 6 cycles starting 5 cycles in.
        n_stall = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [31:0] bv;
                    case (i)
                        0: bv = 32'h3F800000;
                        1: bv = 32'h40000000;
                        2: bv = 32'h40400000;
                        3: bv = 32'h40800000;
                        4: bv = 32'h40A00000;
                        5: bv = 32'h40C00000;
                        6: bv = 32'h40E00000;
                        default: bv = 32'h41000000;
                    endcase
                    send(32'h3F800000, bv, 4'(i), bv, 4'b0000, 1'b1, 1'b0);
                end
                idle();
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stall_cycles", 64'(n_stall), 64'd6);

        // Reset with three ops in flight: none of them may appear.
        send(32'h40000000, 32'h40000000, 4'd1, 32'h0, 4'b0000, 1'b0, 1'b0);
        send(32'h40000000, 32'h40400000, 4'd2, 32'h0, 4'b0000, 1'b0, 1'b0);
        send(32'h40400000, 32'h40400000, 4'd3, 32'h0, 4'b0000, 1'b0, 1'b0);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {63'h0, out_valid}, 64'h0);
        check("midrst_q", {32'h0, q}, 64'h0);
        check("midrst_in_ready", {63'h0, in_ready}, 64'h1);
        @(posedge clk);
        #1;
        send(32'h3F800000, 32'h3F800000, 4'd14, 32'h3F800000, 4'b0000, 1'b1, 1'b1);
        idle();
        drain();
        repeat (10) @(posedge clk);
        #1;

        // Half precision instance.
        h_a = 16'h3E00;
        h_b = 16'h4000;
        h_in_tag = 4'd5;
        h_in_valid = 1'b1;
        e.q = 32'h00004200; e.tag = 4'd5; e.flags = 4'b0000; e.acc = 0; e.lat = 1'b0;
        hsb.push_back(e);
        @(posedge clk);
        #1;
        h_a = 16'h7BFF;
        h_b = 16'h4000;
        h_in_tag = 4'd6;
        e.q = 32'h00007C00; e.tag = 4'd6; e.flags = 4'b0101;
        hsb.push_back(e);
        @(posedge clk);
        #1;
        h_in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
